// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
// Miss-handling and replacement controller for a 4-way, 32-set data cache.
// It performs host lookups, fills read misses from the external bus into a
// victim way chosen by per-set pseudo-LRU, and writes through to the bus.
// It owns the per-set valid bits and PLRU state.
//
// Ports
//   clk0, reset        : clock (rising edge), asynchronous active-high reset
//   host_req/cmd/addr/wdata -> host request (cmd 001 = read, 010 = write)
//   host_ack/err/rdata <- one-cycle completion; err = bus timeout
//   inv_all            : invalidate every line (only honoured when idle)
//   tag_match, way_rdata : per-way tag compare and selected way data from the array
//   hit_way            : way selected for the array read mux
//   arr_we/way/set/data: array write port
//   bus_req/addr/cmd/wdata, bus_grant, bus_rdata, bus_rvalid : external bus
module dcache_refill_ctrl #(
  parameter int padd_size      = 24,
  parameter int data_size      = 32,
  parameter int cmd_size       = 3,
  parameter int timeout_cycles = 255
) (
  input  logic                 clk0,
  input  logic                 reset,
  input  logic                 host_req,
  input  logic [cmd_size-1:0]  host_cmd,
  input  logic [padd_size-1:0] host_addr,
  input  logic [data_size-1:0] host_wdata,
  output logic                 host_ack,
  output logic                 host_err,
  output logic [data_size-1:0] host_rdata,
  input  logic                 inv_all,
  input  logic [3:0]           tag_match,
  input  logic [data_size-1:0] way_rdata,
  output logic [1:0]           hit_way,
  output logic                 arr_we,
  output logic [1:0]           arr_way,
  output logic [4:0]           arr_set,
  output logic [data_size-1:0] arr_data,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic [padd_size-1:0] bus_addr,
  output logic [cmd_size-1:0]  bus_cmd,
  output logic [data_size-1:0] bus_wdata,
  input  logic [data_size-1:0] bus_rdata,
  input  logic                 bus_rvalid
);

  localparam logic [cmd_size-1:0] CmdRead  = cmd_size'(1);
  localparam logic [cmd_size-1:0] CmdWrite = cmd_size'(2);
  // The wait ends on the edge that brings the count up to timeout_cycles.
  localparam logic [7:0] TimeoutLast = 8'(timeout_cycles - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, BUS_REQ, BUS_WAIT, FILL, RESPOND} state_e;

  state_e               state_q;
  logic [cmd_size-1:0]  cmd_q;
  logic [padd_size-1:0] addr_q;
  logic [data_size-1:0] wdata_q;
  logic [data_size-1:0] fillData_q;
  logic [data_size-1:0] hostRdata_q;
  logic [1:0]           victim_q;
  logic [7:0]           timeoutCnt_q;
  logic                 busReq_q;
  logic                 ack_q;
  logic                 err_q;
  logic [3:0]           valid_q [32];
  logic [2:0]           plru_q  [32];

  logic [4:0] setIdx;
  logic [3:0] hitVec;
  logic       hitAny;
  logic [1:0] hitWay;
  logic [1:0] victimWay;
  logic [2:0] curPlru;
  logic [3:0] curValid;

  assign setIdx   = addr_q[4:0];
  assign curValid = valid_q[setIdx];
  assign curPlru  = plru_q[setIdx];
  assign hitVec   = tag_match & curValid;
  assign hitAny   = |hitVec;

  // PLRU tree: bit 0 points at the half to replace next, bits 1/2 pick
  // within the lower/upper pair. Touching a way points both levels away.
  function automatic logic [2:0] plruTouch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n    = p;
    n[0] = ~w[1];
    if (!w[1]) n[1] = ~w[0];
    else       n[2] = ~w[0];
    return n;
  endfunction

  // Lowest-index matching valid way drives the array read mux.
  always_comb begin
    hitWay = 2'd0;
    if      (hitVec[0]) hitWay = 2'd0;
    else if (hitVec[1]) hitWay = 2'd1;
    else if (hitVec[2]) hitWay = 2'd2;
    else if (hitVec[3]) hitWay = 2'd3;
  end

  // Empty ways are always filled first; only a full set consults the PLRU tree.
  always_comb begin
    victimWay = 2'd0;
    if      (!curValid[0]) victimWay = 2'd0;
    else if (!curValid[1]) victimWay = 2'd1;
    else if (!curValid[2]) victimWay = 2'd2;
    else if (!curValid[3]) victimWay = 2'd3;
    else if (!curPlru[0])  victimWay = {1'b0, curPlru[1]};
    else                   victimWay = {1'b1, curPlru[2]};
  end

  // The write-hit update has to land in the LOOKUP cycle itself because it
  // depends on this cycle's tag compare, so the array port is combinational.
  always_comb begin
    arr_we   = 1'b0;
    arr_way  = 2'd0;
    arr_set  = 5'd0;
    arr_data = '0;
    if (state_q == LOOKUP && cmd_q == CmdWrite && hitAny) begin
      arr_we   = 1'b1;
      arr_way  = hitWay;
      arr_set  = setIdx;
      arr_data = wdata_q;
    end else if (state_q == FILL) begin
      arr_we   = 1'b1;
      arr_way  = victim_q;
      arr_set  = setIdx;
      arr_data = fillData_q;
    end
  end

  assign hit_way    = hitWay;
  assign host_ack   = ack_q;
  assign host_err   = err_q;
  assign host_rdata = hostRdata_q;
  assign bus_req    = busReq_q;
  assign bus_addr   = busReq_q ? addr_q  : '0;
  assign bus_cmd    = busReq_q ? cmd_q   : '0;
  assign bus_wdata  = busReq_q ? wdata_q : '0;

  // Main controller. The ack/err/rdata registers default back to zero every
  // cycle so the response is a single-cycle pulse set on entry to RESPOND.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fillData_q   <= '0;
      hostRdata_q  <= '0;
      victim_q     <= 2'd0;
      timeoutCnt_q <= 8'd0;
      busReq_q     <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int s = 0; s < 32; s++) begin
        valid_q[s] <= 4'd0;
        plru_q[s]  <= 3'd0;
      end
    end else begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      hostRdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            for (int s = 0; s < 32; s++) begin
              valid_q[s] <= 4'd0;
              plru_q[s]  <= 3'd0;
            end
          end else if (host_req) begin
            cmd_q   <= host_cmd;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
            if (host_cmd == CmdRead || host_cmd == CmdWrite) begin
              state_q <= LOOKUP;
            end else begin
              ack_q   <= 1'b1;
              state_q <= RESPOND;
            end
          end
        end
        LOOKUP: begin
          if (hitAny) plru_q[setIdx] <= plruTouch(curPlru, hitWay);
          if (cmd_q == CmdRead && hitAny) begin
            hostRdata_q <= way_rdata;
            ack_q       <= 1'b1;
            state_q     <= RESPOND;
          end else begin
            victim_q <= victimWay;
            busReq_q <= 1'b1;
            state_q  <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          if (bus_grant) begin
            if (cmd_q == CmdWrite) begin
              busReq_q <= 1'b0;
              ack_q    <= 1'b1;
              state_q  <= RESPOND;
            end else begin
              timeoutCnt_q <= 8'd0;
              state_q      <= BUS_WAIT;
            end
          end
        end
        BUS_WAIT: begin
          if (bus_rvalid) begin
            fillData_q <= bus_rdata;
            busReq_q   <= 1'b0;
            state_q    <= FILL;
          end else if (timeoutCnt_q == TimeoutLast) begin
            busReq_q <= 1'b0;
            ack_q    <= 1'b1;
            err_q    <= 1'b1;
            state_q  <= RESPOND;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 8'd1;
          end
        end
        FILL: begin
          valid_q[setIdx][victim_q] <= 1'b1;
          plru_q[setIdx]            <= plruTouch(curPlru, victim_q);
          hostRdata_q               <= fillData_q;
          ack_q                     <= 1'b1;
          state_q                   <= RESPOND;
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl
// Directed testbench for dcache_refill_ctrl. The bench plays both the cache
// array (tag_match, way_rdata) and the external bus. Timing is expressed as
// cycle labels: a cycle is labelled by the rising edge that ends it, so the
// value sampled on the falling edge after edge k belongs to cycle k+1.
module tb_dcache_refill_ctrl;

  logic        clk0 = 1'b0;
  logic        reset;
  logic        host_req;
  logic [2:0]  host_cmd;
  logic [23:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic        host_err;
  logic [31:0] host_rdata;
  logic        inv_all;
  logic [3:0]  tag_match;
  logic [31:0] way_rdata;
  logic [1:0]  hit_way;
  logic        arr_we;
  logic [1:0]  arr_way;
  logic [4:0]  arr_set;
  logic [31:0] arr_data;
  logic        bus_req;
  logic        bus_grant;
  logic [23:0] bus_addr;
  logic [2:0]  bus_cmd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  int cyc = 0;
  int errorCount = 0;
  int checkCount = 0;
  int weCount = 0;
  int weDouble = 0;
  int ackCount = 0;
  int busReqCount = 0;
  logic weLast = 1'b0;

  dcache_refill_ctrl dut (
    .clk0(clk0), .reset(reset),
    .host_req(host_req), .host_cmd(host_cmd), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_err(host_err),
    .host_rdata(host_rdata), .inv_all(inv_all), .tag_match(tag_match),
    .way_rdata(way_rdata), .hit_way(hit_way), .arr_we(arr_we),
    .arr_way(arr_way), .arr_set(arr_set), .arr_data(arr_data),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr),
    .bus_cmd(bus_cmd), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid)
  );

  // 10-unit clock; the edge counter lets tasks turn edges into cycle labels.
  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  // Passive monitor: counts array writes, back-to-back writes, acks and bus
  // request cycles so transactions can be checked for side effects.
  always @(negedge clk0) begin
    if (arr_we) weCount++;
    if (arr_we && weLast) weDouble++;
    weLast = arr_we;
    if (host_ack) ackCount++;
    if (bus_req) busReqCount++;
  end

  // Safety net in case the design wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a host request at a falling edge; reqEdge is the edge that samples it.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [23:0] addr, input logic [31:0] wdata,
                               input logic [3:0] tagm, input logic [31:0] wayd, output int reqEdge);
    @(negedge clk0);
    host_req   = 1'b1;
    host_cmd   = cmd;
    host_addr  = addr;
    host_wdata = wdata;
    tag_match  = tagm;
    way_rdata  = wayd;
    reqEdge    = cyc + 1;
  endtask

  task automatic waitBusReq(input int limit, output int riseCycle);
    riseCycle = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk0);
      if (bus_req) begin
        riseCycle = cyc + 1;
        break;
      end
    end
    if (riseCycle < 0) checkOutput("bus_req_never_rose", 32'd0, 32'd1);
  endtask

  // Called at a falling edge; returns at the falling edge after the grant edge.
  task automatic pulseGrant(output int gEdge);
    bus_grant = 1'b1;
    gEdge = cyc + 1;
    @(negedge clk0);
    bus_grant = 1'b0;
  endtask

  task automatic pulseRvalid(input logic [31:0] data, output int rEdge);
    bus_rvalid = 1'b1;
    bus_rdata  = data;
    rEdge = cyc + 1;
    @(negedge clk0);
    bus_rvalid = 1'b0;
  endtask

  // Looks at the current falling edge first, then advances; drops host_req on ack.
  task automatic waitAck(input int limit, output int ackCycle, output logic [31:0] rd, output logic er);
    ackCycle = -1;
    rd = '0;
    er = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (host_ack) begin
        ackCycle = cyc + 1;
        rd = host_rdata;
        er = host_err;
        break;
      end
      @(negedge clk0);
    end
    host_req = 1'b0;
    if (ackCycle < 0) checkOutput("host_ack_never_came", 32'd0, 32'd1);
  endtask

  task automatic doMissRead(input logic [23:0] addr, input logic [3:0] tagm, input logic [31:0] data,
                            input logic [1:0] expWay, input string tag);
    int n, b, g, r, a;
    logic [31:0] rd;
    logic er;
    applyStimulus(3'b001, addr, 32'd0, tagm, 32'd0, n);
    waitBusReq(10, b);
    checkOutput({tag, "_busreq_cycle"}, b, n + 2);
    checkOutput({tag, "_bus_addr"}, {8'd0, bus_addr}, {8'd0, addr});
    pulseGrant(g);
    @(negedge clk0);
    pulseRvalid(data, r);
    checkOutput({tag, "_fill_we"}, {31'd0, arr_we}, 32'd1);
    checkOutput({tag, "_fill_way"}, {30'd0, arr_way}, {30'd0, expWay});
    checkOutput({tag, "_fill_set"}, {27'd0, arr_set}, {27'd0, addr[4:0]});
    checkOutput({tag, "_fill_data"}, arr_data, data);
    waitAck(10, a, rd, er);
    checkOutput({tag, "_ack_cycle"}, a, r + 2);
    checkOutput({tag, "_rdata"}, rd, data);
    checkOutput({tag, "_err"}, {31'd0, er}, 32'd0);
  endtask

  task automatic doHitRead(input logic [23:0] addr, input logic [3:0] tagm, input logic [31:0] wayd,
                           input logic [1:0] expWay, input string tag);
    int n, a, busBefore;
    logic [31:0] rd;
    logic er;
    busBefore = busReqCount;
    applyStimulus(3'b001, addr, 32'd0, tagm, wayd, n);
    @(negedge clk0);
    checkOutput({tag, "_hit_way"}, {30'd0, hit_way}, {30'd0, expWay});
    waitAck(10, a, rd, er);
    checkOutput({tag, "_ack_cycle"}, a, n + 2);
    checkOutput({tag, "_rdata"}, rd, wayd);
    checkOutput({tag, "_no_bus"}, busReqCount, busBefore);
  endtask

  initial begin
    int n, b, g, a, weBefore, ackBefore, busBefore, rTmp;
    logic [31:0] rd;
    logic er;

    reset = 1'b1; host_req = 1'b0; host_cmd = '0; host_addr = '0; host_wdata = '0;
    inv_all = 1'b0; tag_match = '0; way_rdata = '0; bus_grant = 1'b0;
    bus_rdata = '0; bus_rvalid = 1'b0;

    // Outputs while reset is held.
    repeat (2) @(negedge clk0);
    checkOutput("rst_host_ack", {31'd0, host_ack}, 32'd0);
    checkOutput("rst_host_err", {31'd0, host_err}, 32'd0);
    checkOutput("rst_host_rdata", host_rdata, 32'd0);
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_bus_addr", {8'd0, bus_addr}, 32'd0);
    checkOutput("rst_arr_we", {31'd0, arr_we}, 32'd0);
    checkOutput("rst_hit_way", {30'd0, hit_way}, 32'd0);
    reset = 1'b0;

    // Unsupported command: acked next cycle, no error, no bus traffic.
    busBefore = busReqCount;
    applyStimulus(3'b100, 24'h000010, 32'd0, 4'h0, 32'd0, n);
    waitAck(5, a, rd, er);
    checkOutput("badcmd_ack_cycle", a, n + 1);
    checkOutput("badcmd_rdata", rd, 32'd0);
    checkOutput("badcmd_err", {31'd0, er}, 32'd0);
    checkOutput("badcmd_no_bus", busReqCount, busBefore);

    // Cold miss fills way 0 of set 3, then three more tags fill ways 1..3.
    doMissRead(24'h000023, 4'hF, 32'hDEADBEEF, 2'd0, "miss0");
    doMissRead(24'h000043, 4'h0, 32'h11110001, 2'd1, "miss1");
    doMissRead(24'h000063, 4'h0, 32'h22220002, 2'd2, "miss2");
    doMissRead(24'h000083, 4'h0, 32'h33330003, 2'd3, "miss3");

    // Touch way 0; the full set's PLRU then points at way 2.
    doHitRead(24'h000023, 4'b0001, 32'hDEADBEEF, 2'd0, "hit0");
    doMissRead(24'h0000A3, 4'h0, 32'hCAFEF00D, 2'd2, "plru_victim");

    // Read hits, including lowest-index priority among several matches.
    doHitRead(24'h000043, 4'b0010, 32'h12345678, 2'd1, "hit1");
    doHitRead(24'h000063, 4'b1100, 32'h0F0F0F0F, 2'd2, "hit_prio");

    // Fill set 5 so way 3 is valid, then write-hit 0x0000A5 on way 3.
    doMissRead(24'h000005, 4'h0, 32'h50000000, 2'd0, "s5w0");
    doMissRead(24'h000025, 4'h0, 32'h50000001, 2'd1, "s5w1");
    doMissRead(24'h000045, 4'h0, 32'h50000002, 2'd2, "s5w2");
    doMissRead(24'h000065, 4'h0, 32'h50000003, 2'd3, "s5w3");
    applyStimulus(3'b010, 24'h0000A5, 32'h55AA55AA, 4'b1000, 32'd0, n);
    weBefore = weCount;
    @(negedge clk0);
    checkOutput("wr_lookup_we", {31'd0, arr_we}, 32'd1);
    checkOutput("wr_lookup_way", {30'd0, arr_way}, 32'd3);
    checkOutput("wr_lookup_set", {27'd0, arr_set}, 32'd5);
    checkOutput("wr_lookup_data", arr_data, 32'h55AA55AA);
    waitBusReq(10, b);
    checkOutput("wr_busreq_cycle", b, n + 2);
    checkOutput("wr_bus_cmd", {29'd0, bus_cmd}, 32'd2);
    checkOutput("wr_bus_addr", {8'd0, bus_addr}, 32'h0000A5);
    checkOutput("wr_bus_wdata", bus_wdata, 32'h55AA55AA);
    pulseGrant(g);
    waitAck(10, a, rd, er);
    checkOutput("wr_ack_cycle", a, g + 1);
    checkOutput("wr_err", {31'd0, er}, 32'd0);
    checkOutput("wr_we_count", weCount - weBefore, 32'd1);

    // Write miss: no allocation, still written through to the bus.
    applyStimulus(3'b010, 24'h0000C5, 32'h01020304, 4'h0, 32'd0, n);
    weBefore = weCount;
    waitBusReq(10, b);
    checkOutput("wrmiss_bus_wdata", bus_wdata, 32'h01020304);
    pulseGrant(g);
    waitAck(10, a, rd, er);
    checkOutput("wrmiss_ack_cycle", a, g + 1);
    checkOutput("wrmiss_no_we", weCount - weBefore, 32'd0);

    // Timeout: a stray rvalid before the grant is ignored, then no data ever comes.
    applyStimulus(3'b001, 24'h000007, 32'd0, 4'h0, 32'd0, n);
    waitBusReq(10, b);
    weBefore = weCount;
    pulseRvalid(32'hBAD0BAD0, rTmp);
    pulseGrant(g);
    waitAck(300, a, rd, er);
    checkOutput("tmo_ack_cycle", a, g + 256);
    checkOutput("tmo_err", {31'd0, er}, 32'd1);
    checkOutput("tmo_bus_req_low", {31'd0, bus_req}, 32'd0);
    checkOutput("tmo_no_we", weCount - weBefore, 32'd0);
    doMissRead(24'h000007, 4'hF, 32'h0BADCAFE, 2'd0, "tmo_still_invalid");

    // Invalidate everything, then a previously filled line misses again.
    @(negedge clk0);
    inv_all = 1'b1;
    @(negedge clk0);
    inv_all = 1'b0;
    doMissRead(24'h000023, 4'hF, 32'h11112222, 2'd0, "inv_miss");

    // Reset in BUS_WAIT drops bus_req at once and suppresses the ack.
    applyStimulus(3'b001, 24'h000043, 32'd0, 4'h0, 32'd0, n);
    waitBusReq(10, b);
    pulseGrant(g);
    @(negedge clk0);
    ackBefore = ackCount;
    reset = 1'b1;
    host_req = 1'b0;
    #1;
    checkOutput("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
    repeat (2) @(negedge clk0);
    reset = 1'b0;
    repeat (4) @(negedge clk0);
    checkOutput("rst_mid_no_ack", ackCount, ackBefore);
    doMissRead(24'h000023, 4'hF, 32'h77778888, 2'd0, "rst_invalid");

    checkOutput("arr_we_single_cycle", weDouble, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
